// File: rtl/frac_div_monitor_pkg.sv
// Shared types and default constants for the fractional-divider pattern monitor.
package frac_div_monitor_pkg;

    // Tracking FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    // Default 8.7 ratio: three 8-cycle periods followed by seven 9-cycle periods
    localparam int DEF_DIV_E       = 32'sd8;
    localparam int DEF_DIV_O       = 32'sd9;
    localparam int DEF_N_E         = 32'sd3;
    localparam int DEF_N_O         = 32'sd7;
    localparam int DEF_LOCK_FRAMES = 32'sd2;

    // Measured rise-to-rise interval, saturating at its maximum value
    localparam int PERIOD_W = 32'sd5;
    typedef logic [PERIOD_W-1:0] period_t;
    localparam period_t PERIOD_MAX = 5'd31;

    // Saturating 8-bit increment used by the error counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/frac_div_monitor_edge_period_meter.sv
// Rise detector and rise-to-rise interval meter for the divided clock.
// A rise is only reported as a measurement while 'arm' is high, so the first
// rise after reset or after the tracker drops back to idle just re-arms.
module edge_period_meter
    import frac_div_monitor_pkg::*;
(
    input  logic    clk_in,
    input  logic    rst,
    input  logic    clk_div,
    input  logic    arm,
    output logic    rise,
    output logic    meas,
    output period_t pcnt,
    output period_t period_len,
    output logic    period_vld
);

    logic    clk_d_r;
    period_t pcnt_r;
    period_t period_len_r;
    logic    period_vld_r;

    assign rise       = clk_div & ~clk_d_r;
    assign meas       = rise & arm;
    assign pcnt       = pcnt_r;
    assign period_len = period_len_r;
    assign period_vld = period_vld_r;

    // Delay register, saturating interval counter and registered measurement
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            clk_d_r      <= 1'b0;
            pcnt_r       <= 5'd0;
            period_len_r <= 5'd0;
            period_vld_r <= 1'b0;
        end else begin
            clk_d_r <= clk_div;
            if (rise) begin
                pcnt_r <= 5'd1;
            end else if (pcnt_r != PERIOD_MAX) begin
                pcnt_r <= pcnt_r + 5'd1;
            end else begin
                pcnt_r <= pcnt_r;
            end
            period_vld_r <= meas;
            if (meas) begin
                period_len_r <= pcnt_r;
            end else begin
                period_len_r <= period_len_r;
            end
        end
    end

endmodule

// File: rtl/frac_div_monitor.sv
// Fractional clock divider monitor: measures clk_div periods, aligns to the
// short/long frame pattern, tracks it period by period and reports lock,
// frame completion and mismatch/timeout errors.
module frac_div_monitor
    import frac_div_monitor_pkg::*;
#(
    parameter int DIV_E       = DEF_DIV_E,
    parameter int DIV_O       = DEF_DIV_O,
    parameter int N_E         = DEF_N_E,
    parameter int N_O         = DEF_N_O,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
)(
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_div,
    output logic [4:0] period_len,
    output logic       period_vld,
    output logic       frame_done,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int FRAME_LEN = N_E + N_O;
    localparam int IDX_W     = (FRAME_LEN > 32'sd1) ? $clog2(FRAME_LEN) : 32'sd1;
    localparam int GF_W      = $clog2(LOCK_FRAMES + 32'sd1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_NE   = IDX_W'(N_E);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'sd1);
    localparam logic [GF_W-1:0]  GF_MAX   = GF_W'(LOCK_FRAMES);
    localparam logic [GF_W-1:0]  GF_ONE   = GF_W'(32'sd1);
    localparam period_t          LEN_E    = period_t'(DIV_E);
    localparam period_t          LEN_O    = period_t'(DIV_O);

    state_e           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [GF_W-1:0]  good_r, good_s;
    period_t          prev_r, prev_s;
    logic             locked_r, locked_s;
    logic             err_r, err_s;
    logic             fd_r, fd_s;
    logic [7:0]       err_cnt_r, err_cnt_s;

    logic             rise_s;
    logic             meas_s;
    logic             arm_s;
    logic             timeout_s;
    period_t          pcnt_s;
    period_t          exp_len_s;

    assign arm_s     = (state_r != ST_IDLE);
    assign timeout_s = (pcnt_s == PERIOD_MAX) & ~rise_s;
    assign exp_len_s = (idx_r < IDX_NE) ? LEN_E : LEN_O;

    edge_period_meter u_meter (
        .clk_in     (clk_in),
        .rst        (rst),
        .clk_div    (clk_div),
        .arm        (arm_s),
        .rise       (rise_s),
        .meas       (meas_s),
        .pcnt       (pcnt_s),
        .period_len (period_len),
        .period_vld (period_vld)
    );

    // Next-state, frame position, lock and error decisions
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        good_s    = good_r;
        prev_s    = prev_r;
        locked_s  = locked_r;
        err_s     = 1'b0;
        fd_s      = 1'b0;
        err_cnt_s = err_cnt_r;
        case (state_r)
            ST_IDLE: begin
                prev_s = 5'd0;
                idx_s  = '0;
                if (rise_s) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (meas_s) begin
                    prev_s = pcnt_s;
                    // The only long-to-short transition marks the frame start
                    if ((pcnt_s == LEN_E) && (prev_r == LEN_O)) begin
                        state_s = ST_TRACK;
                        idx_s   = IDX_ONE;
                    end else begin
                        state_s = ST_ALIGN;
                    end
                end else if (timeout_s) begin
                    state_s   = ST_IDLE;
                    err_s     = 1'b1;
                    err_cnt_s = sat_inc8(err_cnt_r);
                    locked_s  = 1'b0;
                    good_s    = '0;
                end else begin
                    state_s = ST_ALIGN;
                end
            end
            ST_TRACK: begin
                if (meas_s) begin
                    if (pcnt_s == exp_len_s) begin
                        if (idx_r == IDX_LAST) begin
                            idx_s = '0;
                            fd_s  = 1'b1;
                            if (good_r != GF_MAX) begin
                                good_s = good_r + GF_ONE;
                            end else begin
                                good_s = good_r;
                            end
                            if (good_s == GF_MAX) begin
                                locked_s = 1'b1;
                            end else begin
                                locked_s = locked_r;
                            end
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        // Mismatch: the bad measurement seeds re-alignment
                        state_s   = ST_ALIGN;
                        prev_s    = pcnt_s;
                        err_s     = 1'b1;
                        err_cnt_s = sat_inc8(err_cnt_r);
                        locked_s  = 1'b0;
                        good_s    = '0;
                    end
                end else if (timeout_s) begin
                    state_s   = ST_IDLE;
                    err_s     = 1'b1;
                    err_cnt_s = sat_inc8(err_cnt_r);
                    locked_s  = 1'b0;
                    good_s    = '0;
                end else begin
                    state_s = ST_TRACK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            good_r    <= '0;
            prev_r    <= 5'd0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            fd_r      <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            good_r    <= good_s;
            prev_r    <= prev_s;
            locked_r  <= locked_s;
            err_r     <= err_s;
            fd_r      <= fd_s;
            err_cnt_r <= err_cnt_s;
        end
    end

    assign frame_done = fd_r;
    assign locked     = locked_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_frac_div_monitor.sv
// Self-checking bench for frac_div_monitor: randomized duty/phase stimulus
// compared cycle by cycle against a period-arithmetic reference model.
module tb_frac_div_monitor;

    localparam int DIV_E       = 8;
    localparam int DIV_O       = 9;
    localparam int N_E         = 3;
    localparam int N_O         = 7;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAME       = N_E + N_O;
    localparam int FRAME_CYC   = N_E * DIV_E + N_O * DIV_O;

    localparam int M_IDLE  = 0;
    localparam int M_ALIGN = 1;
    localparam int M_TRACK = 2;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       clk_div = 1'b0;
    logic [4:0] period_len;
    logic       period_vld;
    logic       frame_done;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    frac_div_monitor #(
        .DIV_E(DIV_E), .DIV_O(DIV_O), .N_E(N_E), .N_O(N_O), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .clk_div    (clk_div),
        .period_len (period_len),
        .period_vld (period_vld),
        .frame_done (frame_done),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_cyc, m_last_rise, m_prev, m_pos, m_good;
    bit m_dprev, m_locked;
    int e_len, e_cnt;
    bit e_vld, e_fd, e_err;

    // observation bookkeeping
    int fd_q[$];
    int lock_fd_at;
    bit lock_prev;
    int n_err_obs, n_vld_obs, n_coinc, last_err_len;
    int pat_idx;

    function automatic int pat_len(input int k);
        return (k < N_E) ? DIV_E : DIV_O;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cyc = 0; m_last_rise = 0; m_prev = -1; m_pos = 0; m_good = 0;
        m_dprev = 1'b0; m_locked = 1'b0;
        e_len = 0; e_cnt = 0; e_vld = 1'b0; e_fd = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_fail();
        e_err = 1'b1;
        if (e_cnt < 255) e_cnt++;
        m_locked = 1'b0;
        m_good = 0;
    endtask

    task automatic model_step(input bit d);
        bit r;
        int gap;
        m_cyc++;
        r = d && !m_dprev;
        m_dprev = d;
        e_vld = 1'b0; e_fd = 1'b0; e_err = 1'b0;
        gap = m_cyc - m_last_rise;
        if (m_mode == M_IDLE) begin
            if (r) begin
                m_mode = M_ALIGN; m_prev = -1; m_last_rise = m_cyc;
            end
        end else if (r) begin
            e_vld = 1'b1; e_len = gap; m_last_rise = m_cyc;
            if (m_mode == M_ALIGN) begin
                if (gap == DIV_E && m_prev == DIV_O) begin
                    m_mode = M_TRACK; m_pos = 1;
                end
                m_prev = gap;
            end else if (gap == pat_len(m_pos)) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_pos = 0; e_fd = 1'b1;
                    if (m_good < LOCK_FRAMES) m_good++;
                    if (m_good == LOCK_FRAMES) m_locked = 1'b1;
                end
            end else begin
                model_fail();
                m_mode = M_ALIGN; m_prev = gap;
            end
        end else if (gap >= 31) begin
            model_fail();
            m_mode = M_IDLE;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input bit d);
        clk_div = d;
        model_step(d);
        @(negedge clk_in);
        chk("period_vld", period_vld, e_vld);
        chk("period_len", period_len, e_len);
        chk("frame_done", frame_done, e_fd);
        chk("err", err, e_err);
        chk("locked", locked, m_locked);
        chk("err_cnt", err_cnt, e_cnt);
        if (frame_done) fd_q.push_back(m_cyc);
        if (locked && !lock_prev && lock_fd_at < 0) lock_fd_at = fd_q.size();
        lock_prev = locked;
        if (err) begin
            n_err_obs++;
            last_err_len = period_len;
        end
        if (period_vld) n_vld_obs++;
        if (err && frame_done) n_coinc++;
    endtask

    task automatic per(input int len);
        int hi;
        hi = $urandom_range(len - 1, 1);
        for (int i = 0; i < len; i++) cyc(i < hi);
    endtask

    task automatic play(input int nper, input int stretch_after);
        bit pend;
        pend = 1'b0;
        for (int i = 0; i < nper; i++) begin
            int len;
            len = pat_len(pat_idx);
            if (i == stretch_after) pend = 1'b1;
            if (pend && len == DIV_O) begin
                len = DIV_O + 1;
                pend = 1'b0;
            end
            per(len);
            pat_idx = (pat_idx + 1) % FRAME;
        end
    endtask

    task automatic clear_obs();
        fd_q.delete();
        lock_fd_at = -1;
        n_err_obs = 0;
        n_vld_obs = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_len"}, period_len, 0);
        chk({tag, "_vld"}, period_vld, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_lock"}, locked, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_obs();
        lock_prev = 1'b0;
        n_coinc = 0;
        last_err_len = 0;

        // Reset state
        rst = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_zero("reset");
        rst = 1'b1;

        // Clean pattern from a random mid-frame phase
        pat_idx = $urandom_range(FRAME - 1, 1);
        play(50, -1);
        for (int i = 1; i < fd_q.size(); i++) chk("fd_spacing", fd_q[i] - fd_q[i-1], FRAME_CYC);
        chk("fd_seen", fd_q.size() >= 3, 1);
        chk("lock_at_fd", lock_fd_at, LOCK_FRAMES);
        chk("clean_no_err", n_err_obs, 0);

        // One long period stretched by a cycle
        clear_obs();
        play(12, 3);
        chk("stretch_err_once", n_err_obs, 1);
        chk("stretch_len", last_err_len, DIV_O + 1);
        chk("stretch_unlock", locked, 0);
        clear_obs();
        play(40, -1);
        chk("stretch_relock", locked, 1);
        chk("stretch_cnt", err_cnt, 1);

        // clk_div stuck low
        clear_obs();
        for (int i = 0; i < 40; i++) cyc(1'b0);
        chk("timeout_once", n_err_obs, 1);
        chk("timeout_unlock", locked, 0);
        play(40, -1);
        chk("timeout_relock", locked, 1);
        chk("timeout_cnt", err_cnt, 2);

        // A 31-cycle period is a mismatch, not an extra timeout
        clear_obs();
        per(31);
        play(1, -1);
        chk("p31_err_once", n_err_obs, 1);
        chk("p31_cnt", err_cnt, 3);
        play(40, -1);
        chk("p31_relock", locked, 1);

        // Asynchronous reset mid-period while locked
        cyc(1'b1);
        cyc(1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
        clear_obs();
        play(1, -1);
        chk("no_vld_first_rise", n_vld_obs, 0);
        play(30, -1);
        chk("post_rst_lock", locked, 1);

        // Random mix of pattern, short bad and overlong periods
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(9, 0);
            if (sel < 7) begin
                play(1, -1);
            end else if (sel < 9) begin
                per($urandom_range(20, 2));
            end else begin
                per($urandom_range(40, 25));
            end
        end

        // Error counter saturation with repeated 9,8,7 sequences
        for (int i = 0; i < 300; i++) begin
            per(DIV_O);
            per(DIV_E);
            per(7);
        end
        chk("sat_255", err_cnt, 255);
        play(20, -1);
        per(5);
        per(DIV_O);
        chk("sat_hold", err_cnt, 255);

        chk("err_fd_exclusive", n_coinc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
